// File: rtl/axi_arb_pkg.sv
// ---------------------------------------------------------------------------
// axi_arb_pkg : shared arbitration mode constants and helpers. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package axi_arb_pkg;

  localparam int unsigned ARB_RR    = 0;
  localparam int unsigned ARB_FIXED = 1;

  // Modulo-n increment; idx is always below n at the call sites.
  function automatic int unsigned f_wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/axi_rr_prio_sel.sv
// ---------------------------------------------------------------------------
// axi_rr_prio_sel : combinational rotating-priority search from start_i. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module axi_rr_prio_sel
  import axi_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] start_i,
  output logic [N_REQ-1:0] onehot_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             found_o
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] pos;

  // Scan from the farthest offset down so the nearest set request wins last.
  always_comb begin
    onehot_o = '0;
    idx_o    = start_i;
    found_o  = 1'b0;
    sum      = '0;
    pos      = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, start_i} + (IDX_W + 1)'(k);
      if (sum >= (IDX_W + 1)'(N_REQ)) begin
        sum = sum - (IDX_W + 1)'(N_REQ);
      end
      pos = sum[IDX_W-1:0];
      if (req_i[pos]) begin
        onehot_o      = '0;
        onehot_o[pos] = 1'b1;
        idx_o         = pos;
        found_o       = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/axi_rr_arb_flag_n.sv
// ---------------------------------------------------------------------------
// axi_rr_arb_flag_n : N-way round-robin / fixed-priority arbiter with burst lock. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module axi_rr_arb_flag_n
  import axi_arb_pkg::*;
#(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned IDX_W      = $clog2(N_REQ),
  parameter int unsigned LOCK_BURST = 1,
  parameter int unsigned PRIO_MODE  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req_i,
  input  logic [N_REQ-1:0] last_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [IDX_W-1:0] idx_o,
  output logic [IDX_W-1:0] rr_flag_o,
  output logic             locked_o
);

  logic [IDX_W-1:0] rr_flag_q, rr_flag_d;
  logic             lock_q, lock_d;
  logic [IDX_W-1:0] lock_idx_q, lock_idx_d;

  logic [IDX_W-1:0] sel_start;
  logic [N_REQ-1:0] srch_onehot;
  logic [IDX_W-1:0] srch_idx;
  logic             srch_found;

  logic [N_REQ-1:0] win_onehot;
  logic [IDX_W-1:0] win_idx;
  logic             win_valid;
  logic             hs;

  generate
    if (PRIO_MODE == ARB_FIXED) begin : g_fixed
      assign sel_start = '0;
    end else begin : g_rr
      assign sel_start = rr_flag_q;
    end
  endgenerate

  axi_rr_prio_sel #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_sel (
    .req_i    (req_i),
    .start_i  (sel_start),
    .onehot_o (srch_onehot),
    .idx_o    (srch_idx),
    .found_o  (srch_found)
  );

  // A held lock masks every other requester, even when the owner idles.
  always_comb begin
    win_onehot = '0;
    if (lock_q) begin
      win_valid               = req_i[lock_idx_q];
      win_idx                 = lock_idx_q;
      win_onehot[lock_idx_q]  = req_i[lock_idx_q];
    end else begin
      win_valid  = srch_found;
      win_idx    = srch_idx;
      win_onehot = srch_onehot;
    end
  end

  assign valid_o   = win_valid;
  assign idx_o     = win_valid ? win_idx : rr_flag_q;
  assign gnt_o     = win_onehot & {N_REQ{ready_i}};
  assign rr_flag_o = rr_flag_q;
  assign locked_o  = lock_q;
  assign hs        = win_valid & ready_i;

  always_comb begin
    rr_flag_d  = rr_flag_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    if (hs) begin
      if ((LOCK_BURST == 0) || last_i[win_idx]) begin
        lock_d = 1'b0;
        if (PRIO_MODE == ARB_RR) begin
          rr_flag_d = IDX_W'(f_wrap_inc(32'(win_idx), N_REQ));
        end
      end else begin
        lock_d     = 1'b1;
        lock_idx_d = win_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_flag_q  <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      rr_flag_q  <= rr_flag_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_axi_rr_arb_flag_n.sv
// ---------------------------------------------------------------------------
// tb_axi_rr_arb_flag_n : directed plus randomised checks of four arbiter configurations. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_axi_rr_arb_flag_n;

  localparam int N_C  [4] = '{4, 3, 4, 5};
  localparam bit LB_C [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  localparam bit PR_C [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        ready;
  logic [31:0] req_v  [4];
  logic [31:0] last_v [4];

  logic [3:0] gnt0; logic v0; logic [1:0] idx0; logic [1:0] rr0; logic lk0;
  logic [2:0] gnt1; logic v1; logic [1:0] idx1; logic [1:0] rr1; logic lk1;
  logic [3:0] gnt2; logic v2; logic [1:0] idx2; logic [1:0] rr2; logic lk2;
  logic [4:0] gnt3; logic v3; logic [2:0] idx3; logic [2:0] rr3; logic lk3;

  int checks = 0;
  int errors = 0;

  int m_ptr [4];
  int m_own [4];
  bit m_lk  [4];

  axi_rr_arb_flag_n #(.N_REQ(4), .LOCK_BURST(1), .PRIO_MODE(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req_i(req_v[0][3:0]), .last_i(last_v[0][3:0]),
    .gnt_o(gnt0), .valid_o(v0), .ready_i(ready), .idx_o(idx0), .rr_flag_o(rr0), .locked_o(lk0));
  axi_rr_arb_flag_n #(.N_REQ(3), .LOCK_BURST(0), .PRIO_MODE(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_i(req_v[1][2:0]), .last_i(last_v[1][2:0]),
    .gnt_o(gnt1), .valid_o(v1), .ready_i(ready), .idx_o(idx1), .rr_flag_o(rr1), .locked_o(lk1));
  axi_rr_arb_flag_n #(.N_REQ(4), .LOCK_BURST(0), .PRIO_MODE(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .req_i(req_v[2][3:0]), .last_i(last_v[2][3:0]),
    .gnt_o(gnt2), .valid_o(v2), .ready_i(ready), .idx_o(idx2), .rr_flag_o(rr2), .locked_o(lk2));
  axi_rr_arb_flag_n #(.N_REQ(5), .LOCK_BURST(1), .PRIO_MODE(0)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req_i(req_v[3][4:0]), .last_i(last_v[3][4:0]),
    .gnt_o(gnt3), .valid_o(v3), .ready_i(ready), .idx_o(idx3), .rr_flag_o(rr3), .locked_o(lk3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: scan requesters in priority order starting at the pointer (or 0).
  function automatic void pred(input int i, output bit v, output int w, output bit [31:0] g);
    v = 1'b0;
    w = m_ptr[i];
    g = '0;
    if (m_lk[i]) begin
      if (req_v[i][m_own[i]]) begin
        v = 1'b1;
        w = m_own[i];
      end
    end else begin
      for (int k = 0; k < N_C[i]; k++) begin
        int p;
        p = PR_C[i] ? k : (m_ptr[i] + k) % N_C[i];
        if (!v && req_v[i][p]) begin
          v = 1'b1;
          w = p;
        end
      end
    end
    if (v && ready) g = 32'd1 << w;
  endfunction

  task automatic check_inst(input int i);
    bit v; int w; bit [31:0] g;
    logic [31:0] og, ov, oi, orr, olk;
    case (i)
      0: begin og = 32'(gnt0); ov = 32'(v0); oi = 32'(idx0); orr = 32'(rr0); olk = 32'(lk0); end
      1: begin og = 32'(gnt1); ov = 32'(v1); oi = 32'(idx1); orr = 32'(rr1); olk = 32'(lk1); end
      2: begin og = 32'(gnt2); ov = 32'(v2); oi = 32'(idx2); orr = 32'(rr2); olk = 32'(lk2); end
      default: begin og = 32'(gnt3); ov = 32'(v3); oi = 32'(idx3); orr = 32'(rr3); olk = 32'(lk3); end
    endcase
    pred(i, v, w, g);
    chk($sformatf("u%0d_gnt", i), og, g);
    chk($sformatf("u%0d_valid", i), ov, 32'(v));
    chk($sformatf("u%0d_idx", i), oi, 32'(w));
    chk($sformatf("u%0d_rr", i), orr, 32'(m_ptr[i]));
    chk($sformatf("u%0d_locked", i), olk, 32'(m_lk[i]));
  endtask

  task automatic settle();
    @(negedge clk);
    for (int i = 0; i < 4; i++) check_inst(i);
  endtask

  task automatic adv();
    for (int i = 0; i < 4; i++) begin
      bit v; int w; bit [31:0] g;
      pred(i, v, w, g);
      if (v && ready) begin
        if (!LB_C[i] || last_v[i][w]) begin
          m_lk[i] = 1'b0;
          if (!PR_C[i]) m_ptr[i] = (w + 1) % N_C[i];
        end else begin
          m_lk[i]  = 1'b1;
          m_own[i] = w;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_ptr[i] = 0; m_own[i] = 0; m_lk[i] = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    ready = 1'b0;
    for (int i = 0; i < 4; i++) begin req_v[i] = '0; last_v[i] = '0; end
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    settle();
    chk("reset_rr", 32'(rr0), 0);
    chk("reset_locked", 32'(lk0), 0);
    chk("reset_gnt", 32'(gnt0), 0);
    adv();

    // Rotation on the 3-way instance
    ready = 1'b1;
    req_v[1] = 32'h7; last_v[1] = 32'h7;
    for (int k = 0; k < 6; k++) begin
      settle();
      chk("rot_idx", 32'(idx1), 32'(k % 3));
      chk("rot_rr", 32'(rr1), 32'(k % 3));
      adv();
    end
    req_v[1] = '0;

    // Four-beat burst from req0 with req2 waiting
    req_v[0] = 32'h5;
    for (int b = 1; b <= 4; b++) begin
      last_v[0] = (b == 4) ? 32'h1 : 32'h0;
      settle();
      chk("burst_gnt", 32'(gnt0), 32'h1);
      chk("burst_locked", 32'(lk0), (b == 1) ? 0 : 1);
      adv();
    end
    last_v[0] = 32'hF;
    settle();
    chk("burst_unlocked", 32'(lk0), 0);
    chk("burst_rr", 32'(rr0), 1);
    chk("burst_next_gnt", 32'(gnt0), 32'h4);
    adv();

    // Lock held across a two-cycle gap with req1 pending
    req_v[0] = 32'h3; last_v[0] = 32'h0;
    settle();
    chk("gap_first_gnt", 32'(gnt0), 32'h1);
    adv();
    req_v[0] = 32'h2;
    repeat (2) begin
      settle();
      chk("gap_valid", 32'(v0), 0);
      chk("gap_gnt", 32'(gnt0), 0);
      adv();
    end
    req_v[0] = 32'h3; last_v[0] = 32'h3;
    settle();
    chk("gap_resume_gnt", 32'(gnt0), 32'h1);
    adv();
    settle();
    chk("gap_after_gnt", 32'(gnt0), 32'h2);
    adv();
    req_v[0] = 32'h8; last_v[0] = 32'hF;
    settle();
    chk("wrap_gnt", 32'(gnt0), 32'h8);
    adv();

    // Backpressure: pointer must hold until ready
    req_v[0] = 32'h6; ready = 1'b0;
    repeat (5) begin
      settle();
      chk("bp_valid", 32'(v0), 1);
      chk("bp_idx", 32'(idx0), 1);
      chk("bp_rr", 32'(rr0), 0);
      adv();
    end
    ready = 1'b1;
    settle();
    chk("bp_gnt", 32'(gnt0), 32'h2);
    adv();
    ready = 1'b0;
    settle();
    chk("bp_rr_after", 32'(rr0), 2);
    chk("bp_idx_after", 32'(idx0), 2);
    adv();

    // Fixed priority: req3 starves behind req1
    req_v[0] = '0; ready = 1'b1;
    req_v[2] = 32'hA; last_v[2] = 32'hF;
    repeat (4) begin
      settle();
      chk("fix_idx", 32'(idx2), 1);
      chk("fix_rr", 32'(rr2), 0);
      chk("fix_gnt", 32'(gnt2), 32'h2);
      adv();
    end
    req_v[2] = '0;

    // Asynchronous reset in the middle of a burst owned by req2
    req_v[0] = 32'h4; last_v[0] = 32'h0;
    settle();
    chk("rstb_gnt", 32'(gnt0), 32'h4);
    adv();
    settle();
    chk("rstb_locked", 32'(lk0), 1);
    ready = 1'b0;
    #1;
    rst_n = 1'b0;
    req_v[0] = 32'h5;
    #1;
    chk("rstb_locked_clr", 32'(lk0), 0);
    chk("rstb_rr_clr", 32'(rr0), 0);
    chk("rstb_gnt_clr", 32'(gnt0), 0);
    chk("rstb_valid", 32'(v0), 1);
    chk("rstb_idx", 32'(idx0), 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    settle();
    chk("rstb_after_idx", 32'(idx0), 0);
    adv();

    // Randomised traffic on every configuration
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 4; i++) begin
        req_v[i]  = $urandom & ((32'd1 << N_C[i]) - 1);
        last_v[i] = ($urandom | $urandom) & ((32'd1 << N_C[i]) - 1);
      end
      ready = ($urandom_range(0, 3) != 0);
      settle();
      adv();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
